rx_test_source: RTL
===================

Name: rx_test_source

Overview:
- Parametrised successor of the single fixed debug counter on the RX path: an NCHAN-channel, WIDTH-bit test-pattern generator/mux.
- Sits between the DDC outputs and rx_buffer.
- Driven by the same sample strobe (hb_strobe) as rx_buffer, so the USB path and host software can be verified without RF.
- Configured over the existing serial setting bus (serial_strobe/serial_addr/serial_data).

Parameters:
- NCHAN, 2, channels; 1..8.
- WIDTH, 16, bits per channel sample; 2..16.
- BASE_ADDR, 7'd80, serial address of MODE; SEED is BASE_ADDR+1, CONST is BASE_ADDR+2.

Ports:
- clock  in  1  sample-domain clock (adcclk).
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  enable_rx; low holds generators at their initial state.
- strobe  in  1  sample strobe; one output sample set per pulse.
- serial_strobe  in  1  setting-bus write strobe.
- serial_addr  in  7  setting-bus address.
- serial_data  in  32  setting-bus data.
- ch_in  in  NCHAN*WIDTH  live samples; channel k at [k*WIDTH +: WIDTH].
- ch_out  out  NCHAN*WIDTH  selected samples, same packing.
- out_strobe  out  1  high one cycle when ch_out updates.

Behaviour:
- Reset (reset_n low, async): ch_out=0, out_strobe=0, MODE=0, SEED=32'h1, CONST=0, cnt=0, walk=1, every lfsr[k]=SEED+k.
- Register writes: registered on the cycle serial_strobe=1 and serial_addr matches. MODE uses data[2:0]; SEED and CONST take 32 bits.
- Mode-change reload: any MODE write sets a pending-reload flag. On the next strobe, generators load initial state (cnt=0, walk=1, lfsr[k]=SEED+k) and that sample is produced from the initial state.
- Write on the same cycle as strobe: that strobe still uses the old MODE; the reload happens on the following strobe.
- Latency: ch_out and out_strobe are registered one cycle after strobe. out_strobe = strobe & enable, delayed 1 cycle. ch_out holds between strobes.
- enable low: generators held at initial state, out_strobe=0, ch_out holds its last value.
- Modes (ch k means ch_out channel k, all arithmetic mod 2^WIDTH):
  - 0 PASS: ch k = ch_in k sampled on strobe.
  - 1 COUNT: ch k = cnt + k; then cnt += NCHAN. Wraps silently. With NCHAN=2, WIDTH=16 this matches the legacy counter (I even, Q odd).
  - 2 LFSR: per-channel 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003). Each channel steps once per strobe; output is the low WIDTH bits of the pre-step state. A state of 0, whether loaded or computed, is forced to 32'h1.
  - 3 CONST: even k gets CONST[WIDTH-1:0]; odd k gets CONST[16 +: WIDTH].
  - 4 WALK: ch k = walk rotated left by k within WIDTH bits; walk rotates left by 1 each strobe.
  - 5..7: treated as PASS.
- A SEED write alone does not reload; it takes effect at the next reload.

Decomposition:
- Package/include rx_test_source_defs: mode encodings (MODE_PASS..MODE_WALK), register offsets (OFS_MODE=0, OFS_SEED=1, OFS_CONST=2), LFSR mask 32'h80200003, SEED reset value.
- One sub-module, rx_lfsr32: clock, reset_n, load, step, seed[31:0], state[31:0]. Implements zero-lockup forcing. Instantiated NCHAN times in a generate loop.
- Settings decode reuses setting_reg, one instance per register.

Test Plan:
- Reset, MODE=1, NCHAN=2, enable=1, 4 strobes -> ch_out pairs (0,1),(2,3),(4,5),(6,7); out_strobe exactly one cycle after each strobe.
- COUNT wrap, WIDTH=4, NCHAN=2, 9 strobes -> 9th pair is (0,1) (cnt wrapped from 16 to 0).
- MODE=2, SEED=0 -> ch0 initial state forced to 1 and the next state is 32'h80200003 (ch0 low 16 bits 16'h0003). ch1 starts at 1. No channel ever outputs an all-zero 32-bit state over 1000 strobes.
- MODE=3, CONST=32'hBEEF_1234, NCHAN=4 -> ch_out = 1234,BEEF,1234,BEEF on every strobe; PASS with ch_in changing -> ch_out tracks ch_in with 1-strobe latency.
- MODE write on the same cycle as strobe while in COUNT at cnt=6, then switch to WALK -> that strobe outputs (6,7); the next strobe outputs walk=0x0001/0x0002; the one after 0x0002/0x0004.
- enable deasserted mid-COUNT, and reset_n pulsed between clock edges -> with enable low, ch_out holds and out_strobe=0; on re-enable output restarts at (0,1); reset_n clears outputs immediately (async, no clock edge needed).

Source files
------------

// File: rtl/rx_test_source_pkg.sv
// rx_test_source shared definitions
// mode codes, register offsets, lfsr helpers
package rx_test_source_defs;

  typedef enum logic [2:0] {
    MODE_PASS  = 3'd0,
    MODE_COUNT = 3'd1,
    MODE_LFSR  = 3'd2,
    MODE_CONST = 3'd3,
    MODE_WALK  = 3'd4
  } mode_e;

  localparam logic [6:0] OFS_MODE  = 7'd0;
  localparam logic [6:0] OFS_SEED  = 7'd1;
  localparam logic [6:0] OFS_CONST = 7'd2;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [31:0] SEED_RST  = 32'h1;

  // An all-zero state would lock the lfsr up.
  function automatic logic [31:0] lfsr_fix(
    input logic [31:0] s
  );
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  function automatic logic [31:0] lfsr_next(
    input logic [31:0] s
  );
    return lfsr_fix((s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0));
  endfunction

endpackage

// File: rtl/rx_lfsr32.sv
// rx_lfsr32: 32-bit galois lfsr with load
// load+step loads the seed and steps from it
module rx_lfsr32
  import rx_test_source_defs::*;
#(
  parameter logic [31:0] RST_VAL = SEED_RST
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  logic [31:0] state_q, state_d;
  logic [31:0] base;

  // next state from either the seed or the held state
  always_comb begin
    base    = load ? lfsr_fix(seed) : state_q;
    state_d = state_q;
    if (step)      state_d = lfsr_next(base);
    else if (load) state_d = base;
  end

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= lfsr_fix(RST_VAL);
    else          state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/setting_reg.sv
// setting_reg: one serial setting-bus register
// captures data when strobed at its address
module setting_reg #(
  parameter logic [6:0] ADDR = 7'd0,
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             strobe,
  input  logic [6:0]       addr,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] val_q, val_d;

  // load on an addressed write
  always_comb begin
    val_d = val_q;
    if (strobe && addr == ADDR)
      val_d = data;
  end

  // register storage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) val_q <= RST_VAL;
    else          val_q <= val_d;
  end

  assign out = val_q;

endmodule

// File: rtl/rx_test_source.sv
// rx_test_source: rx-path test pattern mux
// pass, count, lfsr, const and walk patterns
module rx_test_source
  import rx_test_source_defs::*;
#(
  parameter int NCHAN = 2,
  parameter int WIDTH = 16,
  parameter logic [6:0] BASE_ADDR = 7'd80
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   strobe,
  input  logic                   serial_strobe,
  input  logic [6:0]             serial_addr,
  input  logic [31:0]            serial_data,
  input  logic [NCHAN*WIDTH-1:0] ch_in,
  output logic [NCHAN*WIDTH-1:0] ch_out,
  output logic                   out_strobe
);

  logic [2:0]  mode;
  logic [31:0] seed;
  logic [31:0] cval;
  logic        mode_wr;
  logic        adv;

  setting_reg #(
    .ADDR(BASE_ADDR + OFS_MODE), .WIDTH(3), .RST_VAL(3'd0)
  ) u_mode (
    .clock(clock), .reset_n(reset_n),
    .strobe(serial_strobe), .addr(serial_addr),
    .data(serial_data[2:0]), .out(mode)
  );

  setting_reg #(
    .ADDR(BASE_ADDR + OFS_SEED), .WIDTH(32), .RST_VAL(SEED_RST)
  ) u_seed (
    .clock(clock), .reset_n(reset_n),
    .strobe(serial_strobe), .addr(serial_addr),
    .data(serial_data), .out(seed)
  );

  setting_reg #(
    .ADDR(BASE_ADDR + OFS_CONST), .WIDTH(32), .RST_VAL(32'h0)
  ) u_const (
    .clock(clock), .reset_n(reset_n),
    .strobe(serial_strobe), .addr(serial_addr),
    .data(serial_data), .out(cval)
  );

  assign mode_wr = serial_strobe &&
                   (serial_addr == BASE_ADDR + OFS_MODE);
  assign adv = strobe & enable;

  function automatic logic [WIDTH-1:0] rotl(
    input logic [WIDTH-1:0] x,
    input int n
  );
    int s;
    s = n % WIDTH;
    return (x << s) | (x >> (WIDTH - s));
  endfunction

  logic             pend_q, pend_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] walk_q, walk_d;
  logic [WIDTH-1:0] cnt_cur, walk_cur;
  logic [31:0]      lf_state [NCHAN];
  logic [31:0]      lf_cur [NCHAN];
  logic             lf_load;

  // a pending reload makes this strobe start from initial state
  assign cnt_cur  = pend_q ? '0 : cnt_q;
  assign walk_cur = pend_q ? WIDTH'(1) : walk_q;
  assign lf_load  = !enable || (adv && pend_q);

  for (genvar k = 0; k < NCHAN; k++) begin : g_lfsr
    rx_lfsr32 #(
      .RST_VAL(SEED_RST + 32'(k))
    ) u_lfsr (
      .clock(clock), .reset_n(reset_n),
      .load(lf_load), .step(adv),
      .seed(seed + 32'(k)), .state(lf_state[k])
    );
    assign lf_cur[k] = pend_q ? lfsr_fix(seed + 32'(k))
                              : lf_state[k];
  end

  // counter, walker and reload-pending bookkeeping
  always_comb begin
    cnt_d  = cnt_q;
    walk_d = walk_q;
    pend_d = pend_q;
    if (!enable) begin
      cnt_d  = '0;
      walk_d = WIDTH'(1);
    end else if (strobe) begin
      cnt_d  = cnt_cur + WIDTH'(NCHAN);
      walk_d = rotl(walk_cur, 1);
      pend_d = 1'b0;
    end
    if (mode_wr)
      pend_d = 1'b1;
  end

  // generator state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= 1'b0;
      cnt_q  <= '0;
      walk_q <= WIDTH'(1);
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      walk_q <= walk_d;
    end
  end

  logic [NCHAN*WIDTH-1:0] ch_q, ch_d;
  logic                   os_q, os_d;

  // per-channel output select, updated only on enabled strobes
  always_comb begin
    ch_d = ch_q;
    os_d = adv;
    if (adv) begin
      for (int k = 0; k < NCHAN; k++) begin
        case (mode)
          MODE_COUNT:
            ch_d[k*WIDTH +: WIDTH] = cnt_cur + WIDTH'(k);
          MODE_LFSR:
            ch_d[k*WIDTH +: WIDTH] = lf_cur[k][WIDTH-1:0];
          MODE_CONST:
            ch_d[k*WIDTH +: WIDTH] = (k % 2 == 1)
              ? cval[16 +: WIDTH] : cval[WIDTH-1:0];
          MODE_WALK:
            ch_d[k*WIDTH +: WIDTH] = rotl(walk_cur, k);
          default:
            ch_d[k*WIDTH +: WIDTH] = ch_in[k*WIDTH +: WIDTH];
        endcase
      end
    end
  end

  // output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ch_q <= '0;
      os_q <= 1'b0;
    end else begin
      ch_q <= ch_d;
      os_q <= os_d;
    end
  end

  assign ch_out     = ch_q;
  assign out_strobe = os_q;

endmodule
